// File: rtl/inv_mixcolumns_seq.sv
// AES InvMixColumns, iterative. A 128-bit state is latched on start. Each clock
// while running, COLS_PER_CYCLE columns pass through a shared GF(2^8) datapath
// and are written back in place. The finished state is published atomically
// together with a one-cycle done pulse.

// One column of InvMixColumns: out_r = 0E*s_r ^ 0B*s_r+1 ^ 0D*s_r+2 ^ 09*s_r+3.
// The constant multipliers are built from xtime chains, so no lookup tables are used.
module inv_mixcolumns_col (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    // multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    logic [7:0] s0, s1, s2, s3;

    // s0 is the most significant byte of the column (FIPS-197 byte order)
    always_comb begin
        s0    = col_i[31:24];
        s1    = col_i[23:16];
        s2    = col_i[15:8];
        s3    = col_i[7:0];
        col_o = {mule(s0) ^ mulb(s1) ^ muld(s2) ^ mul9(s3),
                 mule(s1) ^ mulb(s2) ^ muld(s3) ^ mul9(s0),
                 mule(s2) ^ mulb(s3) ^ muld(s0) ^ mul9(s1),
                 mule(s3) ^ mulb(s0) ^ muld(s1) ^ mul9(s2)};
    end
endmodule

module inv_mixcolumns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [127:0] data,
    output logic [127:0] inv_mixcolumns_out,
    output logic         busy,
    output logic         done
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic {IDLE, RUN} state_t;

    // Column c of the state is held in word [3-c]. This keeps column 0 in data[127:96].
    state_t                              state_q, state_d;
    logic [3:0][31:0]                    work_q, work_d;
    logic [1:0]                          col_cnt_q, col_cnt_d;
    logic [127:0]                        out_q, out_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;

    logic [COLS_PER_CYCLE-1:0][1:0]      lane_idx;
    logic [COLS_PER_CYCLE-1:0][31:0]     lane_in;
    logic [COLS_PER_CYCLE-1:0][31:0]     lane_out;
    logic [2:0]                          cnt_sum;
    logic                                last_grp;

    // One datapath lane per column handled in a cycle. Lane l works on column col_cnt+l.
    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        assign lane_idx[l] = ~(col_cnt_q + 2'(l));
        assign lane_in[l]  = work_q[lane_idx[l]];
        inv_mixcolumns_col u_col (
            .col_i (lane_in[l]),
            .col_o (lane_out[l])
        );
    end

    // A 3-bit sum lets the counter hit 4, which ends RUN, without wrapping the 2-bit count.
    assign cnt_sum  = {1'b0, col_cnt_q} + 3'(COLS_PER_CYCLE);
    assign last_grp = cnt_sum[2];

    // Next-state logic: accept a start in IDLE, then step through the column groups in RUN.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        col_cnt_d = col_cnt_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    work_d    = data;
                    col_cnt_d = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < COLS_PER_CYCLE; l++) begin
                    work_d[lane_idx[l]] = lane_out[l];
                end
                if (last_grp) begin
                    out_d     = work_d;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    col_cnt_d = 2'd0;
                    state_d   = IDLE;
                end else begin
                    col_cnt_d = cnt_sum[1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs. Reset drops any transform in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            work_q    <= '0;
            col_cnt_q <= 2'd0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            col_cnt_q <= col_cnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign inv_mixcolumns_out = out_q;
    assign busy               = busy_q;
    assign done               = done_q;
endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// Bench for inv_mixcolumns_seq. Three instances are built, with COLS_PER_CYCLE
// set to 1, 2 and 4. Expected results and their due cycle go into a scoreboard
// queue when a start is driven. A negedge monitor pops and compares an entry on
// every done pulse.
module tb_inv_mixcolumns_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en   [3];
    logic [127:0] din  [3];
    logic [127:0] out  [3];
    logic         busy [3];
    logic         done [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [127:0] val;
        int           due;
        int           dut;
    } exp_t;
    exp_t sbq[$];

    localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COL_IN   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] COL_OUT  = 128'hdb135345f20a225c01010101c6c6c6c6;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        inv_mixcolumns_seq #(.COLS_PER_CYCLE(1 << i)) u_dut (
            .clk                (clk),
            .reset              (rst_n),
            .enable             (en[i]),
            .data               (din[i]),
            .inv_mixcolumns_out (out[i]),
            .busy               (busy[i]),
            .done               (done[i])
        );
    end

    function automatic int lat(input int i);
        return 4 >> i;
    endfunction

    // forward MixColumns reference model
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a, b, d, e;
        a = c[31:24]; b = c[23:16]; d = c[15:8]; e = c[7:0];
        return {xt(a) ^ xt(b) ^ b ^ d ^ e,
                a ^ xt(b) ^ xt(d) ^ d ^ e,
                a ^ b ^ xt(d) ^ xt(e) ^ e,
                xt(a) ^ a ^ b ^ d ^ xt(e)};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    // scoreboard monitor: every done must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done dut%0d out=%h at cycle %0d", i, out[i], cyc);
                end else begin
                    e = sbq.pop_front();
                    if (e.dut != i || out[i] !== e.val) begin
                        errors++;
                        $display("FAIL result dut%0d got %h expected %h (dut%0d)", i, out[i], e.val, e.dut);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency dut%0d done at cycle %0d expected %0d", i, cyc, e.due);
                    end
                    checks++;
                    if (busy[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_on_done dut%0d got %b expected 0", i, busy[i]);
                    end
                end
            end
        end
    end

    task automatic start(input int i, input logic [127:0] d, input logic [127:0] expv);
        exp_t e;
        @(negedge clk);
        din[i] = d;
        en[i]  = 1'b1;
        e.val = expv; e.due = cyc + 1 + lat(i); e.dut = i;
        sbq.push_back(e);
        @(negedge clk);
        en[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        bit seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (done[i] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout dut%0d got no done expected done", i);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sbq.size() != 0; n++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out[i] !== '0 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d got out=%h busy=%b done=%b expected all 0",
                         tag, i, out[i], busy[i], done[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin en[i] = 1'b1; din[i] = FIPS_IN; end
        repeat (2) @(negedge clk);
        check_idle_zero("reset_held");
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("after_release");
    endtask

    task automatic test_fips(input int i);
        start(i, FIPS_IN, FIPS_OUT);
        wait_done(i);
    endtask

    task automatic test_columns(input int i);
        start(i, COL_IN, COL_OUT);
        wait_done(i);
    endtask

    // second enable lands while busy and must be ignored
    task automatic test_busy();
        exp_t e;
        @(negedge clk);
        din[0] = COL_IN; en[0] = 1'b1;
        e.val = COL_OUT; e.due = cyc + 5; e.dut = 0;
        sbq.push_back(e);
        @(negedge clk);
        en[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_high got %b expected 1", busy[0]);
        end
        @(negedge clk);
        din[0] = FIPS_IN; en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        wait_done(0);
        repeat (8) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || out[0] !== COL_OUT) begin
            errors++;
            $display("FAIL busy_ignore got busy=%b out=%h expected 0 %h", busy[0], out[0], COL_OUT);
        end
    endtask

    // data wiggles during RUN; previous result must stay on the port until done
    task automatic test_data_change();
        start(0, FIPS_IN, FIPS_OUT);
        din[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        din[0] = {$urandom, $urandom, $urandom, $urandom};
        checks++;
        if (out[0] !== COL_OUT) begin
            errors++;
            $display("FAIL partial_visible got %h expected %h", out[0], COL_OUT);
        end
        wait_done(0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        din[0] = COL_IN; en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_idle_zero("abort_after");
    endtask

    task automatic test_back_to_back(input int i);
        exp_t e;
        int   c0;
        @(negedge clk);
        c0 = cyc;
        din[i] = FIPS_IN; en[i] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            e.val = FIPS_OUT; e.due = c0 + 1 + lat(i) + n * (lat(i) + 1); e.dut = i;
            sbq.push_back(e);
        end
        repeat (3 * (lat(i) + 1)) @(negedge clk);
        en[i] = 1'b0;
        drain();
    endtask

    task automatic test_round_trip(input int i, input int n_blocks);
        logic [127:0] s;
        for (int n = 0; n < n_blocks; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            start(i, mix_state(s), s);
            wait_done(i);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fips(0);
        test_columns(0);
        test_busy();
        test_data_change();
        test_abort();
        test_back_to_back(0);
        for (int i = 1; i < 3; i++) begin
            test_fips(i);
            test_columns(i);
            test_back_to_back(i);
        end
        test_round_trip(0, 1000);
        test_round_trip(1, 300);
        test_round_trip(2, 300);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
